// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - digit-serial BCD add/sub/accumulate/clear unit (optional BCD_SAT_EN: saturating results)
module bcd_serial_adder #(
  parameter int NDIG = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [4*NDIG-1:0] op_a,
  input  logic [4*NDIG-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] result,
  output logic              carry_out,
  output logic              invalid
);

  localparam int W = 4 * NDIG;
  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_ACC = 2'b01;
  localparam logic [1:0] MODE_SUB = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   x_q, y_q, shadow;
  logic [3:0]     idx;
  logic           carry;
`ifdef BCD_SAT_EN
  logic [1:0]     mode_q;
`endif

  logic           bad_a, bad_b, bad;
  logic [W-1:0]   nines_b, x_ld, y_ld, shadow_nx, fin_result;
  logic [4:0]     dsum;
  logic [3:0]     dval;
  logic           dcarry, fin_carry, last;

  always_comb begin
    bad_a   = 1'b0;
    bad_b   = 1'b0;
    nines_b = '0;
    for (int i = 0; i < NDIG; i++) begin
      nines_b[4*i +: 4] = 4'd9 - op_b[4*i +: 4];
      if (op_a[4*i +: 4] > 4'd9) bad_a = 1'b1;
      if (op_b[4*i +: 4] > 4'd9) bad_b = 1'b1;
    end
    case (mode)
      MODE_ADD, MODE_SUB: bad = bad_a | bad_b;
      MODE_ACC:           bad = bad_a;
      default:            bad = 1'b0;
    endcase
  end

  // Operands are pre-arranged so RUN never looks at mode: SUB becomes a + (9-b) + 1.
  always_comb begin
    x_ld = '0;
    y_ld = '0;
    case (mode)
      MODE_ADD: begin x_ld = op_a;   y_ld = op_b;    end
      MODE_ACC: begin x_ld = result; y_ld = op_a;    end
      MODE_SUB: begin x_ld = op_a;   y_ld = nines_b; end
      default:  begin x_ld = '0;     y_ld = '0;      end
    endcase
  end

  always_comb begin
    dsum = {1'b0, x_q[3:0]} + {1'b0, y_q[3:0]} + {4'b0000, carry};
    if (dsum > 5'd9) begin
      dval   = 4'(dsum + 5'd6);
      dcarry = 1'b1;
    end else begin
      dval   = dsum[3:0];
      dcarry = 1'b0;
    end
    shadow_nx = shadow >> 4;
    shadow_nx[W-1 -: 4] = dval;
    last       = (idx == 4'(NDIG - 1));
    fin_result = shadow_nx;
    fin_carry  = dcarry;
`ifdef BCD_SAT_EN
    if (mode_q == MODE_SUB && !dcarry)
      fin_result = '0;
    else if (!mode_q[1] && dcarry)
      fin_result = {NDIG{4'h9}};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = bad ? DONE : RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      shadow    <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      invalid   <= 1'b0;
`ifdef BCD_SAT_EN
      mode_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx    <= '0;
            shadow <= '0;
            if (bad) begin
              invalid <= 1'b1;
            end else begin
              x_q   <= x_ld;
              y_q   <= y_ld;
              carry <= (mode == MODE_SUB);
`ifdef BCD_SAT_EN
              mode_q <= mode;
`endif
            end
          end
        end
        RUN: begin
          x_q    <= x_q >> 4;
          y_q    <= y_q >> 4;
          carry  <= dcarry;
          shadow <= shadow_nx;
          idx    <= idx + 4'd1;
          // Outputs commit only on the edge into DONE; the shadow stays private.
          if (last) begin
            result    <= fin_result;
            carry_out <= fin_carry;
            invalid   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb/tb_bcd_serial_adder.sv - self-checking bench for bcd_serial_adder against a decimal-arithmetic model
module tb_bcd_serial_adder;

  localparam int NDIG = 2;
  localparam int W    = 4 * NDIG;
  localparam int MAXV = 100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy, done, carry_out, invalid;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_result = '0, p_result = '0;
  logic         m_carry = 1'b0, p_carry = 1'b0;
  logic         m_inv = 1'b0, p_inv = 1'b0;
  bit           pending = 1'b0;

  bcd_serial_adder #(.NDIG(NDIG)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .result(result), .carry_out(carry_out), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int s = 0;
    for (int i = NDIG - 1; i >= 0; i--) s = s * 10 + int'(v[4*i +: 4]);
    return s;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] v = '0;
    for (int i = 0; i < NDIG; i++) begin
      v[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return v;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    for (int i = 0; i < NDIG; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // Decimal model: what the operation must produce, from the committed model state.
  task automatic model_op(input logic [1:0] md, input logic [W-1:0] a, input logic [W-1:0] b);
    int s;
    bit bad;
    bad = (md == 2'b00 || md == 2'b10) ? (has_bad(a) || has_bad(b)) :
          (md == 2'b01) ? has_bad(a) : 1'b0;
    p_result = m_result;
    p_carry  = m_carry;
    p_inv    = bad;
    if (!bad) begin
      case (md)
        2'b00, 2'b01: begin
          s = bcd2int(a) + ((md == 2'b00) ? bcd2int(b) : bcd2int(m_result));
          p_carry = (s >= MAXV);
`ifdef BCD_SAT_EN
          p_result = int2bcd((s >= MAXV) ? MAXV - 1 : s);
`else
          p_result = int2bcd(s % MAXV);
`endif
        end
        2'b10: begin
          s = bcd2int(a) - bcd2int(b);
          p_carry = (s >= 0);
`ifdef BCD_SAT_EN
          p_result = int2bcd((s >= 0) ? s : 0);
`else
          p_result = int2bcd((s >= 0) ? s : MAXV + s);
`endif
        end
        default: begin
          p_result = '0;
          p_carry  = 1'b0;
        end
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        check("done_expected", {31'd0, pending}, 32'd1);
        check("result", result, p_result);
        check("carry_out", carry_out, p_carry);
        check("invalid", invalid, p_inv);
        m_result = p_result;
        m_carry  = p_carry;
        m_inv    = p_inv;
        pending  = 1'b0;
      end else begin
        check("result_hold", result, m_result);
        check("carry_hold", carry_out, m_carry);
        check("invalid_hold", invalid, m_inv);
      end
    end
  end

  task automatic run_op(input logic [1:0] md, input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    int n = 0;
    int nbusy = 0;
    bit seen = 1'b0;
    int exp_n;
    @(negedge clk);
    start = 1'b1; mode = md; op_a = a; op_b = b;
    model_op(md, a, b);
    pending = 1'b1;
    exp_n = p_inv ? 1 : NDIG + 1;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (poke && n == 1) begin
        start = 1'b1; mode = 2'b00; op_a = 8'h11; op_b = 8'h22;
      end else begin
        start = 1'b0;
      end
      if (busy) nbusy++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check("done_latency", n, exp_n);
    check("busy_cycles", nbusy, exp_n);
    @(negedge clk);
    check("idle_after_done", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_carry", carry_out, 0);
    check("rst_invalid", invalid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(2'b00, 8'h47, 8'h38, 1'b0);
    check("lit_add_47_38", {result, carry_out}, {8'h85, 1'b0});
    run_op(2'b00, 8'h99, 8'h01, 1'b0);
`ifdef BCD_SAT_EN
    check("lit_add_99_01", {result, carry_out}, {8'h99, 1'b1});
`else
    check("lit_add_99_01", {result, carry_out}, {8'h00, 1'b1});
`endif
    run_op(2'b10, 8'h30, 8'h45, 1'b0);
`ifdef BCD_SAT_EN
    check("lit_sub_30_45", {result, carry_out}, {8'h00, 1'b0});
`else
    check("lit_sub_30_45", {result, carry_out}, {8'h85, 1'b0});
`endif
    run_op(2'b10, 8'h45, 8'h30, 1'b0);
    check("lit_sub_45_30", {result, carry_out}, {8'h15, 1'b1});

    run_op(2'b11, 8'h1A, 8'hFF, 1'b0);
    check("lit_clr", {result, carry_out, invalid}, {8'h00, 1'b0, 1'b0});
    run_op(2'b01, 8'h40, 8'hFF, 1'b1);
    check("lit_acc1", {result, carry_out}, {8'h40, 1'b0});
    run_op(2'b01, 8'h40, 8'hFF, 1'b0);
    check("lit_acc2", {result, carry_out}, {8'h80, 1'b0});
    run_op(2'b01, 8'h40, 8'hFF, 1'b0);
`ifdef BCD_SAT_EN
    check("lit_acc3", {result, carry_out}, {8'h99, 1'b1});
`else
    check("lit_acc3", {result, carry_out}, {8'h20, 1'b1});
`endif

    run_op(2'b00, 8'h1A, 8'h00, 1'b0);
    check("lit_invalid", {31'd0, invalid}, 32'd1);
    run_op(2'b10, 8'h12, 8'hB0, 1'b0);
    run_op(2'b00, 8'h12, 8'h34, 1'b0);
    check("lit_add_after_invalid", {result, carry_out, invalid}, {8'h46, 1'b0, 1'b0});
    run_op(2'b10, 8'h00, 8'h00, 1'b0);
    check("lit_sub_zero", {result, carry_out}, {8'h00, 1'b1});

    @(negedge clk);
    start = 1'b1; mode = 2'b00; op_a = 8'h55; op_b = 8'h44;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    m_result = '0; m_carry = 1'b0; m_inv = 1'b0; pending = 1'b0;
    #1;
    check("midrun_rst_outputs", {busy, done, result, carry_out, invalid}, 0);
    @(negedge clk);
    check("midrun_rst_no_done", {30'd0, busy, done}, 0);
    rst_n = 1'b1;

    run_op(2'b00, 8'h05, 8'h05, 1'b0);
    check("lit_after_reset", {result, carry_out}, {8'h10, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder.md
# bcd_serial_adder

Digit-serial BCD arithmetic unit for the digit datapath, and the parametrised successor to the combinational binary operand adder. It processes NDIG packed BCD digits one digit per clock and supports add, subtract, accumulate and clear modes. A start/busy/done handshake frames each operation, and invalid-digit detection rejects bad operands. It sits between the pin-facing operand capture logic and the digit display/readout logic.

## Interface
- NDIG, default 2: number of BCD digits. Legal range is 1–8. Operand/result width is 4*NDIG.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- mode  in  2  operation, sampled with start:
  - 00: ADD, result = a+b
  - 01: ACC, acc = acc+a
  - 10: SUB, result = a−b
  - 11: CLR
- op_a  in  4*NDIG  packed BCD; digit 0 = bits [3:0].
- op_b  in  4*NDIG  packed BCD; ignored in ACC and CLR.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at completion.
- result  out  4*NDIG  registered result; also serves as the ACC accumulator.
- carry_out  out  1  decimal carry out of the top digit; in SUB it is the inverted borrow.
- invalid  out  1  high if the last accepted operation had a non-BCD digit (>9).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1, latch mode, op_a, op_b and a digit index of 0.
  - If any checked operand digit is >9: set the invalid flag and go to DONE. No arithmetic is performed, and result and carry_out are unchanged.
  - Otherwise: clear the invalid flag and go to RUN.
- Checked digits per mode:
  - ADD and SUB check op_a and op_b.
  - ACC checks op_a only.
  - CLR checks nothing.
- RUN: processes one digit per cycle, from digit 0 up to NDIG−1.
  - Binary-add the two 4-bit digits plus the carry.
  - If the sum is >9, add 6 and set carry=1; otherwise carry=0.
  - Shift the digit into the result shadow.
  - After digit NDIG−1, go to DONE.
- Operands per mode:
  - ADD: a, b, with carry-in 0.
  - SUB: a and the nines-complement of b (9−b per digit), with carry-in 1.
  - ACC: current result and a, with carry-in 0.
  - CLR: zero and zero, so result becomes 0 and carry_out becomes 0.
- SUB outcome:
  - When a≥b: carry_out=1 and result = a−b.
  - When a<b: carry_out=0 and result = 10^NDIG − (b−a), i.e. the ten's complement.
- Overflow in ADD and ACC (sum ≥ 10^NDIG): result wraps modulo 10^NDIG and carry_out=1.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- start is ignored while busy=1; no queuing.
- An asynchronous reset at any time, including mid-RUN, immediately zeroes all state and outputs and returns the FSM to IDLE.
- The partial result is never visible. result, carry_out and invalid change only on the edge that enters DONE.

## Timing
- Reset values: state IDLE; busy=0, done=0, result=0, carry_out=0, invalid=0.
- start is sampled high at edge T0:
  - busy rises after T0.
  - Digit k is computed on edge T0+1+k.
  - The edge at T0+NDIG writes result, carry_out and invalid, and enters DONE.
  - done is high in cycle [T0+NDIG, T0+NDIG+1).
  - busy falls at T0+NDIG+1.
  - Latency from start to done = NDIG cycles.
- Invalid path: done is high in cycle [T0, T0+1), so latency = 1.
- Earliest next accepted start: edge T0+NDIG+1. Back-to-back throughput = one operation per NDIG+1 cycles.
- Outputs hold their value until the next done.

## Configuration
- BCD_SAT_EN defined: saturating arithmetic.
  - ADD/ACC overflow: result = all nines, carry_out=1.
  - SUB with a<b: result = 0, carry_out=0.
- BCD_SAT_EN undefined: wrap behaviour as described in Operation.
- Latency is identical in both builds.

## Test plan
- NDIG=2, reset then ADD 47+38 → done 2 cycles after start; result=0x85, carry_out=0, busy high for 3 cycles.
- ADD 99+01 → result=0x00, carry_out=1. With BCD_SAT_EN: result=0x99, carry_out=1.
- SUB 30−45 → result=0x85, carry_out=0 (BCD_SAT_EN: 0x00). SUB 45−30 → 0x15, carry_out=1.
- CLR, then ACC with op_a=0x40 three times → results 0x40, 0x80, then 0x20 with carry_out=1. A start pulsed while busy is ignored.
- ADD with op_a=0x1A → done 1 cycle after start, invalid=1, result and carry_out unchanged. A following valid ADD clears invalid.
- Assert rst_n low mid-RUN → busy/done/result/carry_out/invalid go to 0 immediately, with no done pulse. A start after reset release is accepted normally.
